req_queue: RTL and testbench
============================

Name: req_queue

Overview:
- Buffered consumer placed directly downstream of the two-input request arbiter.
- Accepts the arbiter's merged 1-bit request method into a small FIFO and replays it to the next stage through the same method style.
- Decouples arbiter grant timing from downstream back-pressure and keeps a saturating count of accepted requests whose payload is 1.
- Method convention: each method is a __ENA/__RDY pair with payload $v. A caller may assert __ENA only while the callee's __RDY is high.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the ones_count statistic.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset. One clock; reset is synchronous and active-high: the block resets on a rising CLK edge when nRST=1.
- enq__ENA  input  1  upstream (arbiter out) invokes enqueue this cycle.
- enq$v  input  1  payload of the enqueue.
- enq__RDY  output  1  enqueue guard; high iff the FIFO is not full.
- out$a__ENA  output  1  block invokes the downstream method this cycle.
- out$a$v  output  1  payload presented downstream; equals the head entry.
- out$a__RDY  input  1  downstream method guard.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ones_count  output  CNT_W  saturating count of accepted enqueues with enq$v=1.

Behaviour:
- Storage: DEPTH x 1-bit array. rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and the MSBs differ.
  - level = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- enq fires when enq__ENA && enq__RDY. It writes mem[wr_ptr index] = enq$v and increments wr_ptr.
- enq__ENA while enq__RDY=0 is a protocol violation. It is ignored: no state change, and the bench flags it.
- enq__RDY = !full. This is registered-state only, with no combinational path from out$a__RDY, and there is no bypass when full.
- Dequeue:
  - out$a__ENA = !empty && out$a__RDY.
  - out$a$v = mem[rd_ptr index], driven 0 when empty.
  - When out$a__ENA=1, rd_ptr increments at the clock edge.
- Latency: data enqueued in cycle N is first visible on out$a in cycle N+1. There is no empty-bypass.
- Simultaneous enq and deq with the FIFO neither empty nor full: both pointers advance and level is unchanged.
- When full, the deq fires but the enq is blocked by RDY. The slot frees for enqueue in the next cycle.
- ones_count increments by 1 on each fired enq with enq$v=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (nRST=1 at an edge): rd_ptr=0, wr_ptr=0, ones_count=0; mem contents are don't-care.
  - Outputs after reset: enq__RDY=1, out$a__ENA=0, out$a$v=0, level=0.
  - Reset mid-operation discards all queued entries. An enq or deq coinciding with the reset edge is dropped.
- There is no X-propagation on outputs: out$a$v is masked to 0 when empty.

Decomposition:
- Shared package reqarb_pkg holds:
  - REQ_QUEUE_DEPTH_DEFAULT = 4.
  - typedef req_v_t (logic, 1 bit).
  - function ptr_w(depth) = $clog2(depth)+1.
- The saturating counter is a natural sub-module, sat_counter, with parameter W and ports CLK, nRST, inc, value. The FIFO pointer logic stays inline.

Test Plan:
- Reset then idle: nRST=1 for 2 cycles then 0, no stimulus -> enq__RDY=1, out$a__ENA=0, out$a$v=0, level=0, ones_count=0.
- Fill and hold: out$a__RDY=0; enqueue v=1,0,1,1 on consecutive cycles -> level goes 1,2,3,4; enq__RDY=0 after the 4th; ones_count=3; out$a$v=1 while stalled.
- Drain order: from the full state, out$a__RDY=1 for 4 cycles -> out$a$v sequence 1,0,1,1 with out$a__ENA=1 each cycle; then level=0 and out$a__ENA=0.
- Streaming: out$a__RDY=1; enqueue an alternating 1/0 pattern every cycle for 20 cycles -> level stays 1 after the first cycle; output matches input delayed by 1 cycle; pointers wrap with no loss.
- Full plus simultaneous deq: FIFO full, out$a__RDY=1 and enq__ENA held (illegal) -> no enqueue that cycle, level drops to 3, and enq__RDY=1 next cycle. The bench flags the protocol violation.
- Reset mid-stream: 2 entries queued, ones_count=5, then assert nRST for 1 cycle alongside an enq -> level=0, ones_count=0, out$a__ENA=0 next cycle, and the enqueued value is never emitted.
- Saturation, with CNT_W=3: 9 enqueues with v=1 -> ones_count reads 7 and holds.

Source files
------------

// File: rtl/reqarb_pkg.sv
// ----------------------------------------------------------------------------
// reqarb_pkg
// Shared definitions for the request arbiter and the request queue.
//   REQ_QUEUE_DEPTH_DEFAULT : default number of queue entries
//   req_v_t                 : 1-bit request payload type
//   ptr_w(depth)            : width of a wrapping FIFO pointer / occupancy
//                             value for a queue of 'depth' entries
// ----------------------------------------------------------------------------
package reqarb_pkg;

    localparam int REQ_QUEUE_DEPTH_DEFAULT = 4;

    typedef logic req_v_t;

    // One extra bit above the index lets full and empty be told apart
    // when the index bits of both pointers are equal.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
//   CLK   : clock, rising edge
//   nRST  : synchronous active-high reset, clears value to 0
//   inc   : add one this cycle (ignored once saturated)
//   value : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] value
);

    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/req_queue.sv
// ----------------------------------------------------------------------------
// req_queue
// Small FIFO that buffers the arbiter's merged 1-bit request method and
// replays it downstream, decoupling grant timing from back-pressure. Also
// keeps a saturating count of accepted requests whose payload is 1.
//   CLK         : clock, rising edge
//   nRST        : synchronous active-high reset
//   enq__ENA    : upstream enqueues this cycle (legal only while enq__RDY)
//   enq_v       : enqueue payload
//   enq__RDY    : high while the FIFO is not full
//   out_a__ENA  : block invokes the downstream method this cycle
//   out_a_v     : head entry, forced to 0 when empty
//   out_a__RDY  : downstream guard
//   level       : occupancy, 0..DEPTH
//   ones_count  : saturating count of accepted enqueues with payload 1
// ----------------------------------------------------------------------------
module req_queue
    import reqarb_pkg::*;
#(
    parameter int DEPTH = REQ_QUEUE_DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      enq__ENA,
    input  logic                      enq_v,
    output logic                      enq__RDY,
    output logic                      out_a__ENA,
    output logic                      out_a_v,
    input  logic                      out_a__RDY,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]          ones_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;

    req_v_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;

    logic            w_empty;
    logic            w_full;
    logic            w_enq_fire;
    logic            w_deq_fire;
    logic [IW-1:0]   w_rd_idx;
    logic [IW-1:0]   w_wr_idx;

    assign w_rd_idx = r_rd_ptr[IW-1:0];
    assign w_wr_idx = r_wr_ptr[IW-1:0];

    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (w_rd_idx == w_wr_idx) && (r_rd_ptr[PW-1] != r_wr_ptr[PW-1]);

    // The enqueue guard depends only on registered state: a dequeue in the
    // same cycle does not open a slot until the next cycle.
    assign w_enq_fire = enq__ENA && !w_full;
    assign w_deq_fire = out_a__RDY && !w_empty;

    assign enq__RDY   = !w_full;
    assign out_a__ENA = w_deq_fire;
    assign out_a_v    = w_empty ? 1'b0 : r_mem[w_rd_idx];
    assign level      = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are valid, and empty slots never reach out_a_v.
    always_ff @(posedge CLK) begin
        if (w_enq_fire) begin
            r_mem[w_wr_idx] <= enq_v;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_ones_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_enq_fire && enq_v),
        .value (ones_count)
    );

endmodule

// File: tb/tb_req_queue.sv
// ----------------------------------------------------------------------------
// tb_req_queue
// Directed bench for req_queue. A queue-based scoreboard records every
// accepted enqueue and is popped whenever the block dequeues. A second
// instance with a 3-bit counter exercises saturation.
// ----------------------------------------------------------------------------
module tb_req_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk;
    logic        rst;
    logic        enq_ena;
    logic        enq_v;
    logic        enq_rdy;
    logic        out_ena;
    logic        out_v;
    logic        out_rdy;
    logic [2:0]  level;
    logic [15:0] ones_count;

    logic        s_enq_ena;
    logic        s_enq_v;
    logic        s_enq_rdy;
    logic        s_out_ena;
    logic        s_out_v;
    logic        s_out_rdy;
    logic [2:0]  s_level;
    logic [2:0]  s_ones_count;

    int          errors;
    int          checks;
    int          violations;

    logic        sb_q [$];
    int          model_ones;
    logic        exp_v;

    req_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .CLK        (clk),
        .nRST       (rst),
        .enq__ENA   (enq_ena),
        .enq_v      (enq_v),
        .enq__RDY   (enq_rdy),
        .out_a__ENA (out_ena),
        .out_a_v    (out_v),
        .out_a__RDY (out_rdy),
        .level      (level),
        .ones_count (ones_count)
    );

    req_queue #(
        .DEPTH (DEPTH),
        .CNT_W (3)
    ) u_sat (
        .CLK        (clk),
        .nRST       (rst),
        .enq__ENA   (s_enq_ena),
        .enq_v      (s_enq_v),
        .enq__RDY   (s_enq_rdy),
        .out_a__ENA (s_out_ena),
        .out_a_v    (s_out_v),
        .out_a__RDY (s_out_rdy),
        .level      (s_level),
        .ones_count (s_ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the main instance. Inputs are applied just after a
    // rising edge, outputs are compared at the falling edge against the
    // scoreboard, then the scoreboard is advanced as the edge will advance
    // the DUT.
    task automatic step(input logic enq, input logic v, input logic rdy, input logic do_rst);
        bit exp_full;
        bit exp_deq;
        enq_ena = enq;
        enq_v   = v;
        out_rdy = rdy;
        rst     = do_rst;
        @(negedge clk);
        exp_full = (sb_q.size() == DEPTH);
        exp_deq  = (sb_q.size() != 0) && rdy;
        exp_v    = (sb_q.size() != 0) ? sb_q[0] : 1'b0;
        check("enq_rdy", enq_rdy, !exp_full);
        check("out_ena", out_ena, exp_deq);
        check("out_v",   out_v,   exp_v);
        check("level",   level,   sb_q.size());
        check("ones",    ones_count, model_ones);
        if (enq && !enq_rdy) begin
            violations++;
            $display("NOTE protocol violation: enq__ENA asserted while enq__RDY=0 at %0t", $time);
        end
        if (do_rst) begin
            sb_q.delete();
            model_ones = 0;
        end else begin
            if (exp_deq) void'(sb_q.pop_front());
            if (enq && !exp_full) begin
                sb_q.push_back(v);
                if (v && model_ones < 65535) model_ones++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        violations = 0;
        model_ones = 0;
        enq_ena    = 1'b0;
        enq_v      = 1'b0;
        out_rdy    = 1'b0;
        s_enq_ena  = 1'b0;
        s_enq_v    = 1'b0;
        s_out_rdy  = 1'b0;
        rst        = 1'b1;

        // Reset for two cycles; outputs are unknown before the first edge.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // Fill and hold with the downstream stalled
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);   // full: enq_rdy=0, level=4, ones=3, head=1

        // Drain order 1,0,1,1
        repeat (4) step(0, 0, 1, 0);
        step(0, 0, 1, 0);   // empty again

        // Streaming alternating pattern, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            step(1, (i % 2 == 0), 1, 0);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Full plus simultaneous dequeue with an illegal enqueue
        repeat (4) step(1, 1, 0, 0);
        step(1, 0, 1, 0);   // violation: dropped, one entry leaves
        step(0, 0, 0, 0);   // level=3, enq_rdy=1
        check("violations", violations, 1);

        // Reset mid-stream: 2 queued entries and ones_count=5
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(1, 1, 1, 0);
        step(0, 0, 0, 0);   // level=2, ones=5
        step(1, 1, 1, 1);   // reset together with an enqueue
        step(0, 0, 1, 0);   // level=0, ones=0, nothing emitted
        step(0, 0, 1, 0);

        // Saturation on the 3-bit counter instance
        s_out_rdy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            s_enq_ena = 1'b1;
            s_enq_v   = 1'b1;
            @(posedge clk);
            #1;
            check("sat_ones", s_ones_count, (i + 1 > 7) ? 7 : i + 1);
        end
        s_enq_ena = 1'b0;
        @(posedge clk);
        #1;
        check("sat_hold", s_ones_count, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
